fetch_sequencer: RTL and testbench

Sequencing controller for the instruction-fetch stage of the 5-stage MIPS-32 pipeline. It drives the IF stage's `stall`, `Next_pc` and `jump_cs` controls, plus the IF/ID flush and ID/EX bubble controls. It handles:
- boot to the reset vector,
- load-use hazard stalls,
- taken-branch/jump redirects with wrong-path squashing,
- halt/resume.

It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/fetch_seq_pkg.sv | 16 +
 rtl/load_use_detect.sv | 24 ++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencing logic.
// No logic of its own; imported by the sequencer and the hazard compare.
// Register-number width and the pipeline NOP encoding live here for reuse.
package fetch_seq_pkg;

    localparam int REG_W = 5;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the ID sources and a load in EX.
// Latency: purely combinational, zero cycles.
// No flow control; the result is sampled by whoever needs it.
module load_use_detect
    import fetch_seq_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             hazard
);

    logic rs_match;
    logic rt_match;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign rs_match = id_rs_used && (id_rs == ex_rd);
    assign rt_match = id_rt_used && (id_rt == ex_rd);
    assign hazard   = ex_mem_read && (ex_rd != '0) && (rs_match || rt_match);

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: boot, load-use stall, branch redirect squash, halt/resume.
// Latency: controls are Mealy on the current cycle; stall_cycles lags by one edge.
// Stall holds PC and IF/ID; flush/bubble insert NOPs on redirect and stall.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
    parameter int          REDIRECT_BUBBLES = 2
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic             stall,
    output logic [31:0]      Next_pc,
    output logic             jump_cs,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic [15:0]      stall_cycles
);

    localparam logic [2:0] RCNT_INIT = 3'(REDIRECT_BUBBLES - 1);

    state_t     state;
    logic [2:0] rcnt;
    logic       hazard;
    logic       redirect_start;

    load_use_detect u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (hazard)
    );

    // A taken branch squashes the ID instruction, so it outranks halt and hazard.
    assign redirect_start = branch_taken && ((state == RUN) || (state == REDIRECT));

    always_comb begin
        stall        = 1'b0;
        jump_cs      = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        Next_pc      = branch_target;
        case (state)
            BOOT: begin
                jump_cs      = 1'b1;
                Next_pc      = RESET_VECTOR;
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
            RUN, REDIRECT: begin
                if (redirect_start) begin
                    jump_cs      = 1'b1;
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (state == REDIRECT) begin
                    flush_if_id = 1'b1;
                end else if (halt_req || hazard) begin
                    stall        = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
            HALT: begin
                stall        = 1'b1;
                bubble_id_ex = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            rcnt  <= 3'd0;
        end else begin
            case (state)
                BOOT: begin
                    state <= (RCNT_INIT == 3'd0) ? RUN : REDIRECT;
                    rcnt  <= RCNT_INIT;
                end
                RUN, REDIRECT: begin
                    if (redirect_start) begin
                        state <= (RCNT_INIT == 3'd0) ? RUN : REDIRECT;
                        rcnt  <= RCNT_INIT;
                    end else if (state == REDIRECT) begin
                        rcnt <= rcnt - 3'd1;
                        if (rcnt == 3'd1) begin
                            state <= RUN;
                        end
                    end else if (halt_req) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a cycle-level model
// built from remaining-flush count, halted flag and a saturating stall tally.
module tb_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int          RB = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_rs_used, id_rt_used, ex_mem_read;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req, resume;
    logic        stall, jump_cs, flush_if_id, bubble_id_ex;
    logic [31:0] Next_pc;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_boot;
    bit m_halted;
    int m_flush_left;
    int m_cnt;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_VECTOR(RV), .REDIRECT_BUBBLES(RB)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .stall         (stall),
        .Next_pc       (Next_pc),
        .jump_cs       (jump_cs),
        .flush_if_id   (flush_if_id),
        .bubble_id_ex  (bubble_id_ex),
        .stall_cycles  (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot       = 1'b1;
        m_halted     = 1'b0;
        m_flush_left = 0;
        m_cnt        = 0;
    endtask

    function automatic bit ref_hazard();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    endfunction

    // Check one cycle at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit e_jump, e_flush, e_bubble, e_stall;
        logic [31:0] e_pc;
        if (rst) model_reset();
        @(negedge clk);
        e_jump = 0; e_flush = 0; e_bubble = 0; e_stall = 0;
        e_pc = branch_target;
        if (m_boot) begin
            e_jump = 1; e_flush = 1; e_bubble = 1; e_pc = RV;
        end else if (m_halted) begin
            e_stall = 1; e_bubble = 1;
        end else if (branch_taken) begin
            e_jump = 1; e_flush = 1; e_bubble = 1;
        end else if (m_flush_left > 0) begin
            e_flush = 1;
        end else if (halt_req || ref_hazard()) begin
            e_stall = 1; e_bubble = 1;
        end
        chk("jump_cs",      {31'd0, jump_cs},      {31'd0, e_jump});
        chk("Next_pc",      Next_pc,               e_pc);
        chk("flush_if_id",  {31'd0, flush_if_id},  {31'd0, e_flush});
        chk("bubble_id_ex", {31'd0, bubble_id_ex}, {31'd0, e_bubble});
        chk("stall",        {31'd0, stall},        {31'd0, e_stall});
        chk("stall_cycles", {16'd0, stall_cycles}, m_cnt);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_boot) begin
                m_boot = 0; m_flush_left = RB - 1;
            end else if (m_halted) begin
                if (resume) m_halted = 0;
            end else if (branch_taken) begin
                m_flush_left = RB - 1;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (halt_req) begin
                m_halted = 1;
            end
            if (e_stall && m_cnt < 65535) m_cnt++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_rs_used = 0; id_rt_used = 0; ex_mem_read = 0;
        branch_taken = 0; branch_target = 32'h0;
        halt_req = 0; resume = 0;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        idle_inputs();
        model_reset();

        // reset and boot
        repeat (3) step();
        chk("rst_next_pc", Next_pc, RV);
        rst = 1'b0;
        step();
        step();
        step();
        chk("boot_cnt_zero", {16'd0, stall_cycles}, 32'd0);

        // load-use stall, then the same pattern against r0
        ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_rt_used = 1;
        step();
        idle_inputs();
        step();
        chk("loaduse_cnt", {16'd0, stall_cycles}, 32'd1);
        ex_mem_read = 1; ex_rd = 0; id_rt = 0; id_rt_used = 1;
        step();
        idle_inputs();
        step();
        chk("r0_no_stall_cnt", {16'd0, stall_cycles}, 32'd1);

        // plain branch
        branch_taken = 1; branch_target = 32'h0000_0040;
        step();
        branch_taken = 0;
        repeat (3) step();

        // branch together with a load-use hazard
        branch_taken = 1; branch_target = 32'h0000_0080;
        ex_mem_read = 1; ex_rd = 7; id_rs = 7; id_rs_used = 1;
        step();
        idle_inputs();
        repeat (2) step();
        chk("br_hazard_cnt", {16'd0, stall_cycles}, 32'd1);

        // halt, ignored branch, resume four cycles later
        base = int'(stall_cycles);
        halt_req = 1;
        step();
        halt_req = 0;
        step();
        branch_taken = 1; branch_target = 32'h0000_0200;
        step();
        branch_taken = 0;
        step();
        resume = 1;
        step();
        resume = 0;
        step();
        chk("halt_cnt_delta", {16'd0, stall_cycles}, base + 5);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            id_rs_used    = 1'($urandom_range(0, 1));
            id_rt_used    = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 5) == 0);
            branch_target = $urandom;
            halt_req      = ($urandom_range(0, 7) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            rst           = ($urandom_range(0, 49) == 0);
            step();
        end
        idle_inputs();
        rst = 0;
        repeat (4) step();

        // asynchronous reset in the middle of a redirect
        branch_taken = 1; branch_target = 32'h0000_0300;
        step();
        branch_taken = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_jump", {31'd0, jump_cs}, 32'd1);
        chk("async_pc", Next_pc, RV);
        chk("async_cnt", {16'd0, stall_cycles}, 32'd0);
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();

        // saturation of the stall counter
        halt_req = 1;
        step();
        halt_req = 0;
        repeat (70000) step();
        chk("sat_cnt", {16'd0, stall_cycles}, 32'h0000_FFFF);
        resume = 1;
        step();
        resume = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
